// File: rtl/fp_adder_pipe.sv
`default_nettype none
// ============================================================================
// Module      : fp_adder_pipe
// Description : Four-stage pipelined IEEE-754-style floating-point adder with
//               valid/ready handshakes on both sides and a global stall.
//               Stage 1 unpacks, classifies and orders the operands by
//               magnitude. Stage 2 aligns the smaller mantissa (G/R/S).
//               Stage 3 adds or subtracts. Stage 4 normalises, rounds, packs
//               and handles special values.
//               Denormal inputs are flushed to signed zero. Results that
//               underflow are also flushed to signed zero.
// Macro       : FP_ROUND_NEAREST_EN - defined: round to nearest even;
//               undefined (default): truncation toward zero.
// Ports       : clk, rst_n (async, active low)
//               in_valid/in_ready, n1, n2 : operand handshake, {s,exp,man}
//               out_valid/out_ready, sum  : result handshake
//               ovf     : finite operands overflowed to infinity
//               invalid : canonical quiet NaN produced
// Revision    : 1.0 - initial pipelined release
// ============================================================================
module fp_adder_pipe #(
    parameter int  EXP_W = 8,
    parameter int  MAN_W = 23,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] n1,
    input  logic [W-1:0] n2,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         ovf,
    output logic         invalid
);

    localparam int c_al_w = MAN_W + 3;               // hidden + man + G + R
    localparam int c_lzw  = $clog2(MAN_W + 5);
    localparam int c_ew   = ((EXP_W > c_lzw) ? EXP_W : c_lzw) + 2;
`ifdef FP_ROUND_NEAREST_EN
    localparam bit c_rne  = 1'b1;
`else
    localparam bit c_rne  = 1'b0;
`endif

    logic w_adv;
    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    // ---------------- stage 1: unpack / compare ----------------
    logic [EXP_W-1:0] w_e1, w_e2, w_ea, w_eb;
    logic [MAN_W:0]   w_sig1, w_sig2, w_ma, w_mb;
    logic [W-2:0]     w_mag1, w_mag2;
    logic             w_z1, w_z2, w_nan1, w_nan2, w_inf1, w_inf2, w_swap, w_sa, w_sb;

    assign w_e1   = n1[W-2:MAN_W];
    assign w_e2   = n2[W-2:MAN_W];
    assign w_z1   = (w_e1 == '0);
    assign w_z2   = (w_e2 == '0);
    assign w_nan1 = (&w_e1) && (|n1[MAN_W-1:0]);
    assign w_nan2 = (&w_e2) && (|n2[MAN_W-1:0]);
    assign w_inf1 = (&w_e1) && !(|n1[MAN_W-1:0]);
    assign w_inf2 = (&w_e2) && !(|n2[MAN_W-1:0]);
    // Zero-exponent operands (including denormals) behave as exact zeros.
    assign w_sig1 = w_z1 ? '0 : {1'b1, n1[MAN_W-1:0]};
    assign w_sig2 = w_z2 ? '0 : {1'b1, n2[MAN_W-1:0]};
    assign w_mag1 = w_z1 ? '0 : n1[W-2:0];
    assign w_mag2 = w_z2 ? '0 : n2[W-2:0];
    // Ties keep n1 as A; equal magnitudes give identical results either way.
    assign w_swap = (w_mag2 > w_mag1);
    assign w_sa   = w_swap ? n2[W-1] : n1[W-1];
    assign w_sb   = w_swap ? n1[W-1] : n2[W-1];
    assign w_ea   = w_swap ? w_e2 : w_e1;
    assign w_eb   = w_swap ? w_e1 : w_e2;
    assign w_ma   = w_swap ? w_sig2 : w_sig1;
    assign w_mb   = w_swap ? w_sig1 : w_sig2;

    logic             r1_valid, r1_sa, r1_sub, r1_zs, r1_sp, r1_nan;
    logic [EXP_W-1:0] r1_ea, r1_eb;
    logic [MAN_W:0]   r1_ma, r1_mb;

    always_ff @(posedge clk) begin
        if (w_adv) begin
            r1_sa  <= w_sa;
            r1_sub <= w_sa ^ w_sb;
            r1_zs  <= w_sa & w_sb;      // sign of an all-zero result
            r1_ea  <= w_ea;
            r1_eb  <= w_eb;
            r1_ma  <= w_ma;
            r1_mb  <= w_mb;
            r1_nan <= w_nan1 || w_nan2 || (w_inf1 && w_inf2 && (n1[W-1] != n2[W-1]));
            r1_sp  <= w_nan1 || w_nan2 || w_inf1 || w_inf2;
        end
    end

    // ---------------- stage 2: align ----------------
    logic [31:0]         w_diff, w_sh;
    logic [2*c_al_w-1:0] w_ext;
    logic [c_al_w:0]     w_b_al;

    assign w_diff = 32'(r1_ea) - 32'(r1_eb);
    // Clamping at the field width keeps every shifted-out bit in the sticky half.
    assign w_sh   = (w_diff >= 32'(c_al_w)) ? 32'(c_al_w) : w_diff;
    assign w_ext  = {r1_mb, 2'b00, {c_al_w{1'b0}}} >> w_sh;
    assign w_b_al = {w_ext[2*c_al_w-1:c_al_w], |w_ext[c_al_w-1:0]};

    logic             r2_valid, r2_sa, r2_sub, r2_zs, r2_sp, r2_nan;
    logic [EXP_W-1:0] r2_ea;
    logic [MAN_W:0]   r2_ma;
    logic [c_al_w:0]  r2_mb;

    always_ff @(posedge clk) begin
        if (w_adv) begin
            r2_sa  <= r1_sa;
            r2_sub <= r1_sub;
            r2_zs  <= r1_zs;
            r2_ea  <= r1_ea;
            r2_ma  <= r1_ma;
            r2_mb  <= w_b_al;
            r2_sp  <= r1_sp;
            r2_nan <= r1_nan;
        end
    end

    // ---------------- stage 3: add / subtract ----------------
    logic [MAN_W+4:0] w_a_x, w_b_x, w_raw;

    assign w_a_x = {1'b0, r2_ma, 3'b000};
    assign w_b_x = {1'b0, r2_mb};
    assign w_raw = r2_sub ? (w_a_x - w_b_x) : (w_a_x + w_b_x);   // A >= B

    logic             r3_valid, r3_sa, r3_zs, r3_sp, r3_nan;
    logic [EXP_W-1:0] r3_ea;
    logic [MAN_W+4:0] r3_sum;

    always_ff @(posedge clk) begin
        if (w_adv) begin
            r3_sa  <= r2_sa;
            r3_zs  <= r2_zs;
            r3_ea  <= r2_ea;
            r3_sum <= w_raw;
            r3_sp  <= r2_sp;
            r3_nan <= r2_nan;
        end
    end

    // ---------------- stage 4: normalise / round / pack ----------------
    logic [c_lzw-1:0] w_lz;
    logic [MAN_W+3:0] w_m;
    logic [c_ew-1:0]  w_exp_n, w_exp_f;
    logic [MAN_W+1:0] w_rnd;
    logic [MAN_W-1:0] w_man;
    logic             w_inc, w_rc, w_uflow;
    logic [W-1:0]     w_res;
    logic             w_ovf, w_inv;

    always_comb begin
        w_lz = c_lzw'(MAN_W + 4);
        for (int i = 0; i <= MAN_W + 3; i++) begin
            if (r3_sum[i]) begin
                w_lz = c_lzw'(MAN_W + 3 - i);     // highest set bit wins
            end
        end
    end

    always_comb begin
        if (r3_sum[MAN_W+4]) begin
            w_m     = {r3_sum[MAN_W+4:2], r3_sum[1] | r3_sum[0]};
            w_exp_n = c_ew'(r3_ea) + c_ew'(1);
        end else begin
            w_m     = r3_sum[MAN_W+3:0] << w_lz;
            w_exp_n = c_ew'(r3_ea) - c_ew'(w_lz);
        end
    end

    assign w_uflow = w_exp_n[c_ew-1] || (w_exp_n == '0);
    assign w_inc   = c_rne && w_m[2] && (w_m[1] || w_m[0] || w_m[3]);
    assign w_rnd   = {1'b0, w_m[MAN_W+3:3]} + (MAN_W+2)'(w_inc);
    assign w_rc    = w_rnd[MAN_W+1];
    assign w_man   = w_rc ? w_rnd[MAN_W:1] : w_rnd[MAN_W-1:0];
    assign w_exp_f = w_exp_n + c_ew'(w_rc);

    always_comb begin
        w_res = {r3_sa, w_exp_f[EXP_W-1:0], w_man};
        w_ovf = 1'b0;
        w_inv = 1'b0;
        if (r3_sp) begin
            if (r3_nan) begin
                w_res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
                w_inv = 1'b1;
            end else begin
                w_res = {r3_sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end
        end else if (r3_sum == '0) begin
            w_res = {r3_zs, {(W-1){1'b0}}};
        end else if (w_uflow) begin
            w_res = {r3_sa, {(W-1){1'b0}}};
        end else if (w_exp_f >= c_ew'({EXP_W{1'b1}})) begin
            w_res = {r3_sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_ovf = 1'b1;
        end
    end

    // ---------------- valid chain and output register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_valid  <= 1'b0;
            r2_valid  <= 1'b0;
            r3_valid  <= 1'b0;
            out_valid <= 1'b0;
            sum       <= '0;
            ovf       <= 1'b0;
            invalid   <= 1'b0;
        end else if (w_adv) begin
            r1_valid  <= in_valid;
            r2_valid  <= r1_valid;
            r3_valid  <= r2_valid;
            out_valid <= r3_valid;
            if (r3_valid) begin
                sum     <= w_res;
                ovf     <= w_ovf;
                invalid <= w_inv;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_adder_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_adder_pipe
// Description : Self-checking bench for fp_adder_pipe (EXP_W=8, MAN_W=23).
//               Directed test-plan cases plus randomized operands compared
//               against an exact wide-integer reference model. Honours
//               FP_ROUND_NEAREST_EN in the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_adder_pipe;

`ifdef FP_ROUND_NEAREST_EN
    localparam bit c_rne = 1'b1;
`else
    localparam bit c_rne = 1'b0;
`endif

    logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready, ovf, invalid;
    logic [31:0] n1, n2, sum;

    fp_adder_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .n1(n1), .n2(n2), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .ovf(ovf), .invalid(invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] sum;
        logic        ovf;
        logic        inv;
        int          acc;
    } exp_t;

    exp_t        q[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    bit          chk_lat  = 1'b0;
    bit          held_v   = 1'b0;
    logic [31:0] held_sum = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Exact reference: operands become wide integers in units of 2^-149.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t         r;
        logic [299:0] ma, mb, mag, rest;
        logic         sa, sb, s, g, st;
        logic [7:0]   ea, eb;
        logic [24:0]  sig;
        int           p, e;
        r.sum = '0; r.ovf = 1'b0; r.inv = 1'b0; r.acc = 0;
        sa = a[31]; sb = b[31]; ea = a[30:23]; eb = b[30:23];
        if ((ea == 8'hFF && a[22:0] != 0) || (eb == 8'hFF && b[22:0] != 0) ||
            (ea == 8'hFF && eb == 8'hFF && sa != sb)) begin
            r.sum = 32'h7FC00000; r.inv = 1'b1; return r;
        end
        if (ea == 8'hFF) begin r.sum = {sa, 8'hFF, 23'h0}; return r; end
        if (eb == 8'hFF) begin r.sum = {sb, 8'hFF, 23'h0}; return r; end
        ma = (ea == 0) ? '0 : (300'({1'b1, a[22:0]}) << (int'(ea) - 1));
        mb = (eb == 0) ? '0 : (300'({1'b1, b[22:0]}) << (int'(eb) - 1));
        if (sa == sb)      begin mag = ma + mb; s = sa; end
        else if (ma >= mb) begin mag = ma - mb; s = sa; end
        else               begin mag = mb - ma; s = sb; end
        if (mag == 0) begin r.sum = {sa & sb, 31'h0}; return r; end
        p = 0;
        for (int i = 0; i < 300; i++) if (mag[i]) p = i;
        e = p - 22;
        if (e <= 0) begin r.sum = {s, 31'h0}; return r; end
        sig  = 25'(mag >> (p - 23));
        g    = (p >= 24) ? mag[p-24] : 1'b0;
        rest = (p >= 25) ? (mag & ((300'(1) << (p - 24)) - 1)) : '0;
        st   = (rest != 0);
        if (c_rne && g && (st || sig[0])) sig = sig + 25'd1;
        if (sig[24]) begin sig = sig >> 1; e++; end
        if (e >= 255) begin r.sum = {s, 8'hFF, 23'h0}; r.ovf = 1'b1; return r; end
        r.sum = {s, 8'(e), sig[22:0]};
        return r;
    endfunction

    // One clock cycle, entered and left at a falling edge.
    task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic ordy, input bit dir, input logic [31:0] dsum,
                         input logic dovf, input logic dinv, output bit accepted);
        exp_t e;
        in_valid = v; n1 = a; n2 = b; out_ready = ordy;
        #1;
        chk("in_ready", in_ready, !out_valid || out_ready);
        if (held_v) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_sum", sum, held_sum);
        end
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("spurious_out", out_valid, 0);
            end else begin
                e = q.pop_front();
                chk("sum", sum, e.sum);
                chk("ovf", ovf, e.ovf);
                chk("invalid", invalid, e.inv);
                if (chk_lat) chk("latency", cyc - e.acc, 4);
            end
        end
        held_v   = out_valid && !out_ready;
        held_sum = sum;
        accepted = in_valid && in_ready;
        if (accepted) begin
            e = model(a, b);
            if (dir) begin e.sum = dsum; e.ovf = dovf; e.inv = dinv; end
            e.acc = cyc;
            q.push_back(e);
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] s, input logic o, input logic iv);
        bit acc;
        cycle(1'b1, a, b, 1'b1, 1'b1, s, o, iv, acc);
    endtask

    task automatic idle(input logic ordy);
        bit acc;
        cycle(1'b0, '0, '0, ordy, 1'b0, '0, 1'b0, 1'b0, acc);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() != 0; i++) idle(1'b1);
        chk("drain_left", q.size(), 0);
        idle(1'b1);
    endtask

    task automatic rand_ops(output logic [31:0] a, output logic [31:0] b);
        logic [31:0] sp[7];
        logic [7:0]  eb;
        sp = '{32'h0, 32'h80000000, 32'h7F800000, 32'hFF800000, 32'h7FC00001,
               32'h00012345, 32'h7F7FFFFF};
        a = $urandom;
        case ($urandom_range(0, 3))
            0: b = $urandom;
            1: begin
                eb = a[30:23] + 8'($urandom_range(0, 3)) - 8'd1;
                b  = {1'($urandom), eb, 23'($urandom)};
            end
            2: b = {~a[31], a[30:3], 3'($urandom)};
            default: b = sp[$urandom_range(0, 6)];
        endcase
        if ($urandom_range(0, 7) == 0) a = sp[$urandom_range(0, 6)];
    endtask

    initial begin
        logic [31:0] a, b;
        logic [31:0] bp_a[6];
        bit          acc;
        int          k;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; n1 = '0; n2 = '0;
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_invalid", invalid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);

        // Latency and operand order
        chk_lat = 1'b1;
        send(32'h41C10000, 32'h446CB000, 32'h4472B800, 1'b0, 1'b0);
        send(32'h446CB000, 32'h41C10000, 32'h4472B800, 1'b0, 1'b0);
        // Mixed signs
        send(32'h40880000, 32'hC0840000, 32'h3E000000, 1'b0, 1'b0);
        send(32'hC0840000, 32'h40880000, 32'h3E000000, 1'b0, 1'b0);
        send(32'hC1020000, 32'h40880000, 32'hC0780000, 1'b0, 1'b0);
        // Rounding and cancellation
        send(32'h3DCCCCCD, 32'h3ECCCCCD, 32'h3F000000, 1'b0, 1'b0);
        send(32'h40880000, 32'hC0880000, 32'h00000000, 1'b0, 1'b0);
        // Overflow and specials
        send(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1'b1, 1'b0);
        send(32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b0, 1'b1);
        send(32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b0, 1'b0);
        send(32'h80000000, 32'h80000000, 32'h80000000, 1'b0, 1'b0);
        send(32'h00000000, 32'hC2280000, 32'hC2280000, 1'b0, 1'b0);
        send(32'h80000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0);
        drain();

        // Backpressure: consumer stalls in relative cycles 5..8
        chk_lat = 1'b0;
        for (int i = 0; i < 6; i++) bp_a[i] = 32'h3F800000 + 32'(i << 20);
        k = 0;
        for (int c = 0; c < 30 && k < 6; c++) begin
            cycle(1'b1, bp_a[k], 32'h40000000, !(c >= 5 && c <= 8), 1'b0, '0, 1'b0, 1'b0, acc);
            if (acc) k++;
        end
        chk("bp_all_accepted", k, 6);
        drain();

        // Reset with operations in flight
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 32'h40400000 + 32'(i), 32'h3F800000, 1'b1, 1'b0, '0, 1'b0, 1'b0, acc);
        end
        in_valid = 1'b0;
        #1;
        chk("pre_rst_valid", out_valid, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_sum", sum, 0);
        q.delete();
        held_v = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) idle(1'b1);
        chk_lat = 1'b1;
        send(32'h41C10000, 32'h446CB000, 32'h4472B800, 1'b0, 1'b0);
        drain();

        // Randomized stream against the reference model
        chk_lat = 1'b0;
        for (int i = 0; i < 400; i++) begin
            rand_ops(a, b);
            cycle($urandom_range(0, 9) != 0, a, b, $urandom_range(0, 4) != 0,
                  1'b0, '0, 1'b0, 1'b0, acc);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fp_adder_pipe.md
Name: fp_adder_pipe

Overview:
- Parametrised, pipelined IEEE-754-style floating-point adder.
- Successor to the combinational single-precision adder.
- Generic exponent/mantissa widths; 4-stage pipeline with valid/ready handshakes on both sides.
- Adds overflow and invalid flags and defined special-value handling.
- Sits between an operand producer and a result consumer in the datapath, one add per cycle at full throughput.

Parameters:
- EXP_W, 8: exponent field width (bias = 2^(EXP_W-1)-1).
- MAN_W, 23: stored mantissa width (hidden bit excluded).
- W (derived, 1+EXP_W+MAN_W): operand/result width, not overridable.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  n1/n2 valid.
- in_ready  output  1  block accepts operands this cycle.
- n1  input  W  operand 1 {sign, exp, man}.
- n2  input  W  operand 2.
- out_valid  output  1  sum/flags valid.
- out_ready  input  1  consumer accepts result.
- sum  output  W  result.
- ovf  output  1  result overflowed to infinity (finite inputs only).
- invalid  output  1  NaN produced.

Behaviour:
- Reset (async, rst_n=0):
  - All stage valid bits clear; out_valid=0.
  - sum=0, ovf=0, invalid=0.
  - in_ready=1 once rst_n deasserts.
  - Reset mid-operation discards all in-flight operations.
- Handshake:
  - Transfer in when in_valid&in_ready; transfer out when out_valid&out_ready.
  - Global advance enable: adv = !out_valid | out_ready; in_ready = adv.
  - While adv=0, all stage registers hold; sum/flags stable while out_valid & !out_ready.
  - No bubbles: back-to-back operands each cycle give back-to-back results.
- Latency: exactly 4 cycles from input transfer to out_valid, when unstalled.
- Stage 1, unpack/compare:
  - Exp=0 is treated as zero; denormals are flushed to signed zero.
  - Exp all-ones is inf/NaN.
  - Swap so operand A has the larger magnitude: exp first, then mantissa.
  - Result sign = sign of A.
  - Order of n1/n2 must not change the result.
- Stage 2, align:
  - Shift B mantissa (with hidden bit) right by expA-expB.
  - Keep guard and round bits; OR shifted-out bits into sticky.
  - Shift amounts >= MAN_W+3 leave only sticky.
- Stage 3, add/sub:
  - Add if signs match, else subtract (A-B, never negative).
  - Width MAN_W+5: carry + hidden + man + G/R/S.
- Stage 4, normalise/round/pack:
  - Carry-out: shift right 1, exp+1, fold into sticky.
  - Otherwise left-shift by leading-zero count, decrementing exp.
  - Exp underflow (<=0) flushes to signed zero.
  - Rounding per Optional Feature.
  - A rounding mantissa carry increments exp.
  - Exp reaching all-ones gives ±inf, ovf=1.
- Special cases (decided in stage 1, carried down the pipe):
  - Any NaN input, or inf + -inf: canonical quiet NaN {0, all-ones, 1 followed by zeros}, invalid=1.
  - inf + finite or inf + same-sign inf: that inf, ovf=0.
  - Exact cancellation x + (-x): +0.
  - 0 + x = x exactly; -0 + -0 = -0.

Optional Feature:
- Macro: FP_ROUND_NEAREST_EN.
- Defined: round-to-nearest-even using G/R/S.
  - Increment when G & (R|S|lsb).
- Undefined: truncation (round toward zero).
  - G/R/S discarded; matches the earlier adder's results.
- Overflow to inf applies in both modes.

Test Plan:
- Latency/order: n1=0x41C10000 (24.125), n2=0x446CB000 (946.75), then swapped next cycle, out_ready=1.
  - out_valid at cycles 4 and 5, both sum=0x4472B800 (970.875), flags 0.
- Mixed sign: 0x40880000 (4.25) + 0xC0840000 (-4.125) -> 0x3E000000 (0.125).
  - Swapped order gives the same result.
  - 0xC1020000 (-8.125) + 0x40880000 -> 0xC0780000 (-3.875).
- Rounding/cancellation:
  - 0x3DCCCCCD + 0x3ECCCCCD -> 0x3F000000, both macro settings.
  - 0x40880000 + 0xC0880000 -> 0x00000000.
- Overflow/specials:
  - 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, ovf=1.
  - 0x7F800000 + 0xFF800000 -> 0x7FC00000, invalid=1.
  - 0x7F800000 + 0x3F800000 -> 0x7F800000, ovf=0.
- Backpressure:
  - Stream 6 operands with out_ready=0 for cycles 5-8.
  - in_ready falls with out_ready; sum held stable.
  - All 6 results delivered in order, none lost or duplicated.
- Reset mid-flight: assert rst_n=0 with 3 operations in flight.
  - out_valid=0 and sum=0 immediately (asynchronous).
  - No stale results after release.
  - Next operation appears 4 cycles after acceptance.
